// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcode constants, immediate formats, FSM state
// encoding and the pure decode helper functions.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN    = 1'b0;
  localparam state_t ST_SQUASH = 1'b1;

  function automatic logic is_rv32i(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // Unknown opcodes fall back to FMT_R so they carry a zero immediate.
  function automatic imm_fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: return FMT_I;
      OP_STORE:                                      return FMT_S;
      OP_BRANCH:                                     return FMT_B;
      OP_LUI, OP_AUIPC:                              return FMT_U;
      OP_JAL:                                        return FMT_J;
      default:                                       return FMT_R;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ins, input imm_fmt_e fmt);
    case (fmt)
      FMT_I:   return {{20{ins[31]}}, ins[31:20]};
      FMT_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   return {ins[31:12], 12'd0};
      FMT_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 hardwired to 0.
module regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : mem_q[raddr2_i];

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage with register-file read and JAL redirect/squash FSM.
// Optional DECODE_BYPASS_EN forwards same-cycle writeback data to the operand outputs.
module instr_decode
  import decode_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic [13:0] addr_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        valid_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rd_o,
  output logic [6:0]  opcode_o,
  output logic [13:0] addr_o,
  output logic        illegal_o,
  output logic        pcsrc_o,
  output logic [13:0] target_o
);

  localparam int CNT_W = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);

  logic [6:0]  opcode;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] imm;
  logic [31:0] rf_rd1, rf_rd2, rs1_val, rs2_val;
  logic        run;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        valid_q, valid_d, pcsrc_q, pcsrc_d, illegal_q, illegal_d;
  logic [13:0] target_q, target_d, addr_q;
  logic [31:0] imm_q, rs1_q, rs2_q;
  logic [4:0]  rd_q;
  logic [6:0]  opcode_q;

  assign opcode  = instr_i[6:0];
  assign rs1_idx = instr_i[19:15];
  assign rs2_idx = instr_i[24:20];
  assign imm     = imm_of(instr_i, fmt_of(opcode));
  assign run     = (state_q == ST_RUN);

  regfile u_regfile (
    .clk_i    (clk),
    .we_i     (wb_en_i),
    .waddr_i  (wb_rd_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (rs1_idx),
    .raddr2_i (rs2_idx),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

`ifdef DECODE_BYPASS_EN
  assign rs1_val = (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_idx)) ? wb_data_i : rf_rd1;
  assign rs2_val = (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_idx)) ? wb_data_i : rf_rd2;
`else
  assign rs1_val = rf_rd1;
  assign rs2_val = rf_rd2;
`endif

  // Words sampled while squashing are killed; a JAL among them never redirects.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = run;
    illegal_d = run && !is_rv32i(opcode);
    pcsrc_d   = 1'b0;
    target_d  = target_q;
    if (run) begin
      if (opcode == OP_JAL) begin
        pcsrc_d  = 1'b1;
        target_d = addr_i + imm[13:0];
        if (SQUASH_CYCLES > 0) begin
          state_d = ST_SQUASH;
          cnt_d   = CNT_W'(SQUASH_CYCLES);
        end
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q <= 1) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      pcsrc_q   <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
      addr_q    <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      opcode_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      pcsrc_q   <= pcsrc_d;
      illegal_q <= illegal_d;
      target_q  <= target_d;
      addr_q    <= addr_i;
      imm_q     <= imm;
      rd_q      <= instr_i[11:7];
      opcode_q  <= opcode;
      rs1_q     <= rs1_val;
      rs2_q     <= rs2_val;
    end
  end

  assign valid_o    = valid_q;
  assign pcsrc_o    = pcsrc_q;
  assign illegal_o  = illegal_q;
  assign target_o   = target_q;
  assign addr_o     = addr_q;
  assign imm_o      = imm_q;
  assign rd_o       = rd_q;
  assign opcode_o   = opcode_q;
  assign rs1_data_o = rs1_q;
  assign rs2_data_o = rs2_q;

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have parameter SQUASH_CYCLES, default 2: number of fetched words discarded after a decode-stage redirect.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-high (asserted = 1).
REQ-004 SHALL have port instr_i, input, 32: fetched instruction word.
REQ-005 SHALL have port addr_i, input, 14: byte address of instr_i.
REQ-006 SHALL have ports wb_en_i (1), wb_rd_i (5), wb_data_i (32), inputs: writeback write enable, destination index and data.
REQ-007 SHALL have port valid_o, output, 1: decoded outputs hold a live instruction.
REQ-008 SHALL have ports rs1_data_o and rs2_data_o, outputs, 32 each: source operand values.
REQ-009 SHALL have ports imm_o (output, 32), rd_o (output, 5) and opcode_o (output, 7): sign-extended immediate, destination index and opcode.
REQ-010 SHALL have ports addr_o (output, 14) and illegal_o (output, 1): instruction address and unknown-opcode flag.
REQ-011 SHALL have ports pcsrc_o (output, 1) and target_o (output, 14): redirect request to fetch.

Function
REQ-012 SHALL sample instr_i and addr_i at every rising clk edge and present the decoded result on registered outputs one cycle later.
REQ-013 SHALL decode the immediate by RV32I format (I, S, B, U, J), selected by opcode; R-type yields imm_o=0.
REQ-014 SHALL contain a 32x32 register file with x0 reading 0 and writes to x0 ignored.
REQ-015 SHALL write the register file at the rising edge when wb_en_i=1.
REQ-016 SHALL, on decoding JAL (opcode 1101111) in state RUN, assert pcsrc_o for exactly one cycle with target_o=(addr_i+J-imm) mod 2^14.
REQ-017 SHALL implement FSM RUN/SQUASH: RUN->SQUASH on JAL; SQUASH lasts SQUASH_CYCLES cycles via a down-counter, then ->RUN.
REQ-018 SHALL force valid_o=0, pcsrc_o=0 and illegal_o=0 for words sampled in SQUASH; a JAL arriving in SQUASH SHALL be ignored.
REQ-019 SHALL set illegal_o=1 and valid_o=1 for an opcode outside the RV32I base set, with no redirect.
REQ-020 SHALL let target_o wrap silently; addr_i=0x3FFC with J-imm +8 gives target_o=0x0004.
REQ-021 SHALL keep target_o at its last value while pcsrc_o=0.

Reset
REQ-022 SHALL, while rst_n=1, clear valid_o, pcsrc_o, illegal_o, target_o, addr_o, imm_o, rd_o, opcode_o, rs1_data_o and rs2_data_o to 0 and set state RUN with the squash counter at 0.
REQ-023 SHALL abort an in-progress squash when reset is asserted mid-squash; the first word after reset release SHALL decode normally.
REQ-024 SHALL leave register-file contents unreset, except x0.

Configuration
REQ-025 SHALL, with DECODE_BYPASS_EN defined, forward wb_data_i to rs1_data_o/rs2_data_o when wb_en_i=1 and wb_rd_i equals the source index (nonzero) in the same cycle.
REQ-026 SHALL, without DECODE_BYPASS_EN, return the pre-write register value in that same-cycle case.

Structure
REQ-027 SHALL take opcode constants, the immediate-format enum and the FSM state typedef from shared package decode_pkg.
REQ-028 SHALL place the register file in sub-module regfile (two async read ports, one sync write port).

Verification
REQ-029 SHALL pass: write x5=0x1234 then instr ADDI x6,x5,7 -> next cycle rs1_data_o=0x1234, imm_o=7, rd_o=6, valid_o=1.
REQ-030 SHALL pass: JAL imm=+16 at addr 0x0040 -> pcsrc_o=1 for one cycle with target_o=0x0050; the next 2 words give valid_o=0.
REQ-031 SHALL pass: JAL at addr 0x3FFC with imm +8 -> target_o=0x0004.
REQ-032 SHALL pass: same-cycle wb to x7=0xAA plus read of x7 -> 0xAA with DECODE_BYPASS_EN, old value without it.
REQ-033 SHALL pass: opcode 0000000 -> illegal_o=1, valid_o=1, pcsrc_o=0; write x0=5 then read x0 -> 0.
REQ-034 SHALL pass: rst_n=1 asserted during squash -> all outputs 0 immediately; the first word after release decodes with valid_o=1.
